// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC credit link.
// Holds the per-channel link FSM state encoding and the width function
// used to size the credit counter.
package noc_pkg;

  // Link FSM: IDLE between packets, BODY after a head flit until its tail.
  typedef enum logic [0:0] {
    LINK_IDLE = 1'b0,
    LINK_BODY = 1'b1
  } link_state_e;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : noc_pkg

// File: rtl/noc_link_monitor.sv
// Per-channel link monitor: upstream-view credit counter, packet FSM and
// sticky protocol error flags. Optional perf counters when
// NOC_LINK_PERF_EN is defined.
module noc_link_monitor
  import noc_pkg::*;
#(
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CW                = cw_of(FLIT_BUFFER_DEPTH)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic                  send,
  input  logic                  is_tail,
  input  logic [DEST_WIDTH-1:0] dest,
  input  logic                  credit,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_avail,
  output logic                  pkt_active,
  output logic                  err_underflow,
  output logic                  err_overflow,
  output logic                  err_dest_change
`ifdef NOC_LINK_PERF_EN
  ,
  output logic [31:0]           flit_count,
  output logic [31:0]           pkt_count
`endif
);

  localparam logic [CW-1:0] DEPTH = CW'(FLIT_BUFFER_DEPTH);

  logic [CW-1:0]         count_q, count_d;
  logic                  underflow_set, overflow_set, dest_err_set;
  link_state_e           state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;

  // Credit counter next value: a send and a returned credit cancel out;
  // otherwise the count clamps at 0 / DEPTH and flags the violation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned -- that is what keeps this block latch-free.
    count_d       = count_q;
    underflow_set = 1'b0;
    overflow_set  = 1'b0;
    if (send && !credit) begin
      if (count_q == '0) underflow_set = 1'b1;
      else               count_d = count_q - CW'(1);
    end else if (credit && !send) begin
      if (count_q == DEPTH) overflow_set = 1'b1;
      else                  count_d = count_q + CW'(1);
    end
  end

  // Packet FSM next state: a non-tail flit in IDLE opens a packet and
  // latches its destination; every later flit must match it.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    dest_err_set = 1'b0;
    unique case (state_q)
      LINK_IDLE: begin
        if (send && !is_tail) begin
          state_d = LINK_BODY;
          dest_d  = dest;
        end
      end
      LINK_BODY: begin
        if (send) begin
          if (dest != dest_q) dest_err_set = 1'b1;
          if (is_tail)        state_d = LINK_IDLE;
        end
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  // State registers: counter starts full, FSM idle, error flags sticky.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_noc) begin
      count_q         <= DEPTH;
      state_q         <= LINK_IDLE;
      dest_q          <= '0;
      err_underflow   <= 1'b0;
      err_overflow    <= 1'b0;
      err_dest_change <= 1'b0;
    end else begin
      count_q         <= count_d;
      state_q         <= state_d;
      dest_q          <= dest_d;
      err_underflow   <= err_underflow   | underflow_set;
      err_overflow    <= err_overflow    | overflow_set;
      err_dest_change <= err_dest_change | dest_err_set;
    end
  end

  assign credit_count = count_q;
  assign credit_avail = (count_q != '0);
  assign pkt_active   = (state_q == LINK_BODY);

`ifdef NOC_LINK_PERF_EN
  logic [31:0] flit_cnt_q, pkt_cnt_q;

  // Input-side traffic counters; both wrap naturally at 2^32.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (send) begin
      flit_cnt_q <= flit_cnt_q + 32'd1;
      if (is_tail) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`endif

endmodule : noc_link_monitor

// File: rtl/noc_credit_link.sv
// NoC router-to-router credit link: NUM_LINKS independent channels, each
// with NUM_PIPELINE register stages on the flit path and on the credit
// return path, plus a link monitor per channel.
// Optional build macro: NOC_LINK_PERF_EN adds flit_count / pkt_count.
module noc_credit_link
  import noc_pkg::*;
#(
  parameter int NUM_LINKS         = 4,
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int NUM_PIPELINE      = 2,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                                  clk_noc,
  input  logic                                  rst_noc,
  input  logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  data_in,
  input  logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]  dest_in,
  input  logic [0:NUM_LINKS-1]                  is_tail_in,
  input  logic [0:NUM_LINKS-1]                  send_in,
  output logic [0:NUM_LINKS-1]                  credit_out,
  output logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  data_out,
  output logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]  dest_out,
  output logic [0:NUM_LINKS-1]                  is_tail_out,
  output logic [0:NUM_LINKS-1]                  send_out,
  input  logic [0:NUM_LINKS-1]                  credit_in,
  output logic [0:NUM_LINKS-1]                  credit_avail,
  output logic [0:NUM_LINKS-1][cw_of(FLIT_BUFFER_DEPTH)-1:0] credit_count,
  output logic [0:NUM_LINKS-1]                  pkt_active,
  output logic [0:NUM_LINKS-1]                  err_underflow,
  output logic [0:NUM_LINKS-1]                  err_overflow,
  output logic [0:NUM_LINKS-1]                  err_dest_change
`ifdef NOC_LINK_PERF_EN
  ,
  output logic [0:NUM_LINKS-1][31:0]            flit_count,
  output logic [0:NUM_LINKS-1][31:0]            pkt_count
`endif
);

  localparam int CW = cw_of(FLIT_BUFFER_DEPTH);

  for (genvar ch = 0; ch < NUM_LINKS; ch++) begin : g_ch

    if (NUM_PIPELINE == 0) begin : g_comb
      // Zero-stage link: straight wires, valids forced low during reset.
      assign send_out[ch]    = send_in[ch]   & ~rst_noc;
      assign credit_out[ch]  = credit_in[ch] & ~rst_noc;
      assign data_out[ch]    = data_in[ch];
      assign dest_out[ch]    = dest_in[ch];
      assign is_tail_out[ch] = is_tail_in[ch];
    end else begin : g_pipe
      logic [NUM_PIPELINE-1:0]                 send_q, credit_q, tail_q;
      logic [NUM_PIPELINE-1:0][FLIT_WIDTH-1:0] data_q;
      logic [NUM_PIPELINE-1:0][DEST_WIDTH-1:0] dest_q;

      // Valid shift registers: reset drops every in-flight flit/credit.
      always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
          send_q   <= '0;
          credit_q <= '0;
        end else begin
          send_q[0]   <= send_in[ch];
          credit_q[0] <= credit_in[ch];
          for (int s = 1; s < NUM_PIPELINE; s++) begin
            send_q[s]   <= send_q[s-1];
            credit_q[s] <= credit_q[s-1];
          end
        end
      end

      // Payload shift registers, qualified downstream by send_q.
      always_ff @(posedge clk_noc) begin
        // NOTE: payload stages carry no reset; their contents are only
        // observed alongside a valid bit, which is reset above.
        data_q[0] <= data_in[ch];
        dest_q[0] <= dest_in[ch];
        tail_q[0] <= is_tail_in[ch];
        for (int s = 1; s < NUM_PIPELINE; s++) begin
          data_q[s] <= data_q[s-1];
          dest_q[s] <= dest_q[s-1];
          tail_q[s] <= tail_q[s-1];
        end
      end

      assign send_out[ch]    = send_q[NUM_PIPELINE-1];
      assign credit_out[ch]  = credit_q[NUM_PIPELINE-1];
      assign data_out[ch]    = data_q[NUM_PIPELINE-1];
      assign dest_out[ch]    = dest_q[NUM_PIPELINE-1];
      assign is_tail_out[ch] = tail_q[NUM_PIPELINE-1];
    end

    // Credits are counted as they reach the upstream router (credit_out).
    noc_link_monitor #(
      .DEST_WIDTH        (DEST_WIDTH),
      .FLIT_BUFFER_DEPTH (FLIT_BUFFER_DEPTH),
      .CW                (CW)
    ) u_mon (
      .clk_noc         (clk_noc),
      .rst_noc         (rst_noc),
      .send            (send_in[ch]),
      .is_tail         (is_tail_in[ch]),
      .dest            (dest_in[ch]),
      .credit          (credit_out[ch]),
      .credit_count    (credit_count[ch]),
      .credit_avail    (credit_avail[ch]),
      .pkt_active      (pkt_active[ch]),
      .err_underflow   (err_underflow[ch]),
      .err_overflow    (err_overflow[ch]),
      .err_dest_change (err_dest_change[ch])
`ifdef NOC_LINK_PERF_EN
      ,
      .flit_count      (flit_count[ch]),
      .pkt_count       (pkt_count[ch])
`endif
    );
  end

endmodule : noc_credit_link

// File: tb/tb_noc_credit_link.sv
// Scoreboard bench for noc_credit_link: a 4-channel, 2-stage instance
// checked through expected-flit/credit queues, plus a 2-channel
// zero-stage instance checked for same-cycle pass-through.
module tb_noc_credit_link;

  localparam int NL = 4;
  localparam int FW = 64;
  localparam int DW = 4;
  localparam int NP = 2;
  localparam int DEPTH = 4;
  localparam int CW = noc_pkg::cw_of(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-stage instance
  logic [0:NL-1][FW-1:0] data_in, data_out;
  logic [0:NL-1][DW-1:0] dest_in, dest_out;
  logic [0:NL-1]         is_tail_in, is_tail_out, send_in, send_out;
  logic [0:NL-1]         credit_in, credit_out, credit_avail, pkt_active;
  logic [0:NL-1]         err_underflow, err_overflow, err_dest_change;
  logic [0:NL-1][CW-1:0] credit_count;
`ifdef NOC_LINK_PERF_EN
  logic [0:NL-1][31:0]   flit_count, pkt_count;
`endif

  // zero-stage instance
  logic [0:1][FW-1:0] data_in0, data_out0;
  logic [0:1][DW-1:0] dest_in0, dest_out0;
  logic [0:1]         is_tail_in0, is_tail_out0, send_in0, send_out0;
  logic [0:1]         credit_in0, credit_out0, credit_avail0, pkt_active0;
  logic [0:1]         err_underflow0, err_overflow0, err_dest_change0;
  logic [0:1][CW-1:0] credit_count0;
`ifdef NOC_LINK_PERF_EN
  logic [0:1][31:0]   flit_count0, pkt_count0;
`endif

  noc_credit_link #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(NP), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_noc(clk), .rst_noc(rst),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .credit_avail(credit_avail), .credit_count(credit_count),
    .pkt_active(pkt_active), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_dest_change(err_dest_change)
`ifdef NOC_LINK_PERF_EN
    , .flit_count(flit_count), .pkt_count(pkt_count)
`endif
  );

  noc_credit_link #(
    .NUM_LINKS(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut0 (
    .clk_noc(clk), .rst_noc(rst),
    .data_in(data_in0), .dest_in(dest_in0), .is_tail_in(is_tail_in0), .send_in(send_in0),
    .credit_out(credit_out0),
    .data_out(data_out0), .dest_out(dest_out0), .is_tail_out(is_tail_out0), .send_out(send_out0),
    .credit_in(credit_in0), .credit_avail(credit_avail0), .credit_count(credit_count0),
    .pkt_active(pkt_active0), .err_underflow(err_underflow0), .err_overflow(err_overflow0),
    .err_dest_change(err_dest_change0)
`ifdef NOC_LINK_PERF_EN
    , .flit_count(flit_count0), .pkt_count(pkt_count0)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
    int          at;
  } flit_t;

  typedef struct {
    int ch;
    int at;
  } credit_t;

  flit_t   exp_flits[$];
  credit_t exp_credits[$];

  task automatic drive_flit(input int ch, input logic [63:0] d, input logic [3:0] dst,
                            input logic tl);
    flit_t f;
    send_in[ch]    = 1'b1;
    data_in[ch]    = d;
    dest_in[ch]    = dst;
    is_tail_in[ch] = tl;
    f.ch = ch; f.data = d; f.dest = dst; f.tail = tl; f.at = cyc + NP;
    exp_flits.push_back(f);
  endtask

  task automatic drive_credit(input int ch);
    credit_t c;
    credit_in[ch] = 1'b1;
    c.ch = ch; c.at = cyc + NP;
    exp_credits.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    send_in   = '0;
    credit_in = '0;
  endtask

  // Monitor: pops the scoreboard whenever the 2-stage DUT presents output.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NL; ch++) begin
        if (send_out[ch]) begin
          if (exp_flits.size() == 0) begin
            check("unexpected_flit", 64'(ch), 64'hFFFF);
          end else begin
            flit_t f;
            f = exp_flits.pop_front();
            check("flit_chan", 64'(ch), 64'(f.ch));
            check("flit_data", data_out[ch], f.data);
            check("flit_dest_tail", {59'd0, dest_out[ch], is_tail_out[ch]}, {59'd0, f.dest, f.tail});
            check("flit_latency", 64'(cyc), 64'(f.at));
          end
        end
        if (credit_out[ch]) begin
          if (exp_credits.size() == 0) begin
            check("unexpected_credit", 64'(ch), 64'hFFFF);
          end else begin
            credit_t c;
            c = exp_credits.pop_front();
            check("credit_chan", 64'(ch), 64'(c.ch));
            check("credit_latency", 64'(cyc), 64'(c.at));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    send_in = '0; credit_in = '0; data_in = '0; dest_in = '0; is_tail_in = '0;
    send_in0 = '0; credit_in0 = '0; data_in0 = '0; dest_in0 = '0; is_tail_in0 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_send_out", 64'(send_out), 64'd0);
    check("rst_credit_out", 64'(credit_out), 64'd0);
    rst = 1'b0;
    step();

    // Reset state
    check("reset_count0", 64'(credit_count[0]), 64'd4);
    check("reset_count3", 64'(credit_count[3]), 64'd4);
    check("reset_avail", 64'(credit_avail), 64'hF);
    check("reset_pkt_active", 64'(pkt_active), 64'd0);
    check("reset_errs", {52'd0, err_underflow, err_overflow, err_dest_change}, 64'd0);

    // One flit out after 2 cycles; credit back after 2 cycles
    drive_flit(0, 64'hDEAD_BEEF_0123_4567, 4'd2, 1'b1);
    step();
    check("count_after_send", 64'(credit_count[0]), 64'd3);
    repeat (4) step();
    drive_credit(0);
    repeat (3) step();
    check("count_after_credit", 64'(credit_count[0]), 64'd4);

    // Drain all credits, then underflow
    for (int i = 0; i < 4; i++) begin
      drive_flit(0, 64'h1000 + 64'(i), 4'(i), 1'b1);
      step();
    end
    check("count_drained", 64'(credit_count[0]), 64'd0);
    check("avail_drained", 64'(credit_avail[0]), 64'd0);
    check("no_underflow_yet", 64'(err_underflow[0]), 64'd0);
    drive_flit(0, 64'h2000, 4'd7, 1'b1);
    step();
    check("underflow_flag", 64'(err_underflow[0]), 64'd1);
    check("underflow_count", 64'(credit_count[0]), 64'd0);

    // Return 4 credits, then one too many
    for (int i = 0; i < 4; i++) begin
      drive_credit(0);
      step();
    end
    repeat (3) step();
    check("count_refilled", 64'(credit_count[0]), 64'd4);
    check("no_overflow_yet", 64'(err_overflow[0]), 64'd0);
    drive_credit(0);
    repeat (3) step();
    check("overflow_flag", 64'(err_overflow[0]), 64'd1);
    check("overflow_count", 64'(credit_count[0]), 64'd4);

    // Count 2, then send and credit in the same cycle
    drive_flit(0, 64'h3000, 4'd1, 1'b1);
    step();
    drive_flit(0, 64'h3001, 4'd1, 1'b1);
    step();
    check("count_two", 64'(credit_count[0]), 64'd2);
    drive_credit(0);
    step();
    step();
    drive_flit(0, 64'h3002, 4'd1, 1'b1);
    step();
    check("count_simul", 64'(credit_count[0]), 64'd2);
    check("underflow_sticky", 64'(err_underflow[0]), 64'd1);

    // Destination change inside a packet on ch1
    drive_flit(1, 64'hAAAA_0001, 4'd3, 1'b0);
    step();
    check("pkt_active_head", 64'(pkt_active[1]), 64'd1);
    check("no_dest_err_head", 64'(err_dest_change[1]), 64'd0);
    drive_flit(1, 64'hAAAA_0002, 4'd5, 1'b0);
    step();
    check("dest_change_flag", 64'(err_dest_change[1]), 64'd1);
    check("pkt_active_body", 64'(pkt_active[1]), 64'd1);
    drive_flit(1, 64'hAAAA_0003, 4'd3, 1'b1);
    step();
    check("pkt_active_tail", 64'(pkt_active[1]), 64'd0);
    check("dest_err_sticky", 64'(err_dest_change[1]), 64'd1);
    check("indep_ch0_dest", 64'(err_dest_change[0]), 64'd0);
    check("indep_ch2_errs", {61'd0, err_underflow[2], err_overflow[2], err_dest_change[2]}, 64'd0);
    check("indep_ch2_count", 64'(credit_count[2]), 64'd4);
    repeat (3) step();

    // Reset with two flits and a credit in flight on ch2
    drive_credit(2);
    drive_flit(2, 64'hBBBB_0001, 4'd9, 1'b1);
    step();
    drive_flit(2, 64'hBBBB_0002, 4'd9, 1'b1);
    step();
    #1;
    rst = 1'b1;
    void'(exp_flits.pop_back());
    void'(exp_flits.pop_back());
    void'(exp_credits.pop_back());
    #1;
    check("midrst_send_out", 64'(send_out), 64'd0);
    check("midrst_credit_out", 64'(credit_out), 64'd0);
    check("midrst_count2", 64'(credit_count[2]), 64'd4);
    check("midrst_count0", 64'(credit_count[0]), 64'd4);
    check("midrst_errs", {52'd0, err_underflow, err_overflow, err_dest_change}, 64'd0);
    check("midrst_pkt_active", 64'(pkt_active), 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_send_out", 64'(send_out), 64'd0);
    rst = 1'b0;
    repeat (4) step();

    // Zero-stage pass-through with monitors active
    send_in0[1]    = 1'b1;
    data_in0[1]    = 64'h5555_AAAA_5555_AAAA;
    dest_in0[1]    = 4'd6;
    is_tail_in0[1] = 1'b1;
    credit_in0[0]  = 1'b1;
    #1;
    check("p0_send_out", 64'(send_out0), 64'b01);
    check("p0_data_out", data_out0[1], 64'h5555_AAAA_5555_AAAA);
    check("p0_dest_out", 64'(dest_out0[1]), 64'd6);
    check("p0_credit_out", 64'(credit_out0), 64'b10);
    @(posedge clk);
    #1;
    send_in0  = '0;
    credit_in0 = '0;
    check("p0_count1", 64'(credit_count0[1]), 64'd3);
    check("p0_overflow0", 64'(err_overflow0[0]), 64'd1);
    check("p0_count0", 64'(credit_count0[0]), 64'd4);

`ifdef NOC_LINK_PERF_EN
    // Three 2-flit packets on ch3
    for (int p = 0; p < 3; p++) begin
      drive_flit(3, 64'hC000 + 64'(2 * p), 4'd4, 1'b0);
      step();
      drive_flit(3, 64'hC001 + 64'(2 * p), 4'd4, 1'b1);
      step();
    end
    check("perf_flits", 64'(flit_count[3]), 64'd6);
    check("perf_pkts", 64'(pkt_count[3]), 64'd3);
    force dut.g_ch[3].u_mon.flit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.g_ch[3].u_mon.flit_cnt_q;
    drive_flit(3, 64'hC100, 4'd4, 1'b1);
    step();
    check("perf_wrap", 64'(flit_count[3]), 64'd0);
`endif

    // Drain: everything expected must have appeared
    repeat (6) step();
    check("flits_all_seen", 64'(exp_flits.size()), 64'd0);
    check("credits_all_seen", 64'(exp_credits.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_noc_credit_link
